// File: rtl/l2_cache_pkg.sv
// Shared L2 tag-array definitions: geometry, entry layout and controller states.
// Entry layout: valid flag at VALID_BIT above the tag field.
package l2_cache_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int TAG_WIDTH  = 16;
    localparam int DATA_WIDTH = 17;
    localparam int VALID_BIT  = 16;

    typedef struct packed {
        logic                 valid;
        logic [TAG_WIDTH-1:0] tag;
    } l2_entry_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } l2_state_t;

endpackage

// File: rtl/l2_tag_ctrl.sv
// L2 tag-array controller: clears the external tag SRAM after reset/flush,
// then serves single-cycle-issue tag lookups and entry updates.
module l2_tag_ctrl
    import l2_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = l2_cache_pkg::ADDR_WIDTH,
    parameter int TAG_WIDTH  = l2_cache_pkg::TAG_WIDTH,
    parameter int DATA_WIDTH = l2_cache_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  lk_valid,
    output logic                  lk_ready,
    input  logic [ADDR_WIDTH-1:0] lk_index,
    input  logic [TAG_WIDTH-1:0]  lk_tag,

    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_WIDTH-1:0] upd_index,
    input  logic [DATA_WIDTH-1:0] upd_entry,

    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [DATA_WIDTH-1:0] rsp_entry,

    input  logic                  flush_req,
    output logic                  init_done,

    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    l2_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    logic                  upd_acc;
    logic                  lk_acc;
    logic                  bypass;

    logic                  lk_pend;
    logic                  byp_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] byp_entry_q;
    logic [DATA_WIDTH-1:0] rd_entry;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        upd_ready  = 1'b0;
        lk_ready   = 1'b0;
        upd_acc    = 1'b0;
        lk_acc     = 1'b0;
        bypass     = 1'b0;
        sram_csb0  = 1'b1;
        sram_addr0 = cnt;
        sram_din0  = '0;
        sram_csb1  = 1'b1;
        sram_addr1 = lk_index;

        case (state)
            ST_INIT: begin
                sram_csb0 = 1'b0;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == '1) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                upd_ready = !flush_req;
                lk_ready  = !flush_req;
                upd_acc   = upd_valid && !flush_req;
                lk_acc    = lk_valid && !flush_req;
                // Same-set update and lookup: serve the lookup from upd_entry so
                // the SRAM never sees a read and write to one address together.
                bypass    = upd_acc && lk_acc && (upd_index == lk_index);
                if (upd_acc) begin
                    sram_csb0  = 1'b0;
                    sram_addr0 = upd_index;
                    sram_din0  = upd_entry;
                end
                if (lk_acc && !bypass) begin
                    sram_csb1 = 1'b0;
                end
                if (flush_req) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase

        if (rst) begin
            sram_csb0 = 1'b1;
            sram_csb1 = 1'b1;
            upd_ready = 1'b0;
            lk_ready  = 1'b0;
        end
    end

    assign rd_entry = byp_q ? byp_entry_q : sram_dout1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            cnt         <= '0;
            init_done   <= 1'b0;
            lk_pend     <= 1'b0;
            byp_q       <= 1'b0;
            tag_q       <= '0;
            byp_entry_q <= '0;
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_entry   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_done <= (state_nxt == ST_RUN);

            lk_pend <= lk_acc;
            if (lk_acc) begin
                tag_q       <= lk_tag;
                byp_q       <= bypass;
                byp_entry_q <= upd_entry;
            end

            rsp_valid <= lk_pend;
            if (lk_pend) begin
                rsp_entry <= rd_entry;
                rsp_hit   <= rd_entry[DATA_WIDTH-1] && (rd_entry[TAG_WIDTH-1:0] == tag_q);
            end
        end
    end

endmodule

// File: tb/tb_l2_tag_ctrl.sv
// Directed bench for l2_tag_ctrl with a behavioural 1-write/1-read SRAM.
module tb_l2_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        lk_valid;
    logic        lk_ready;
    logic [6:0]  lk_index;
    logic [15:0] lk_tag;
    logic        upd_valid;
    logic        upd_ready;
    logic [6:0]  upd_index;
    logic [16:0] upd_entry;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [16:0] rsp_entry;
    logic        flush_req;
    logic        init_done;
    logic        sram_csb0;
    logic [6:0]  sram_addr0;
    logic [16:0] sram_din0;
    logic        sram_csb1;
    logic [6:0]  sram_addr1;
    logic [16:0] sram_dout1;

    logic [16:0] mem [0:127];

    int tests = 0;
    int fails = 0;

    l2_tag_ctrl #(
        .ADDR_WIDTH(7),
        .TAG_WIDTH (16),
        .DATA_WIDTH(17)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lk_valid  (lk_valid),
        .lk_ready  (lk_ready),
        .lk_index  (lk_index),
        .lk_tag    (lk_tag),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_index (upd_index),
        .upd_entry (upd_entry),
        .rsp_valid (rsp_valid),
        .rsp_hit   (rsp_hit),
        .rsp_entry (rsp_entry),
        .flush_req (flush_req),
        .init_done (init_done),
        .sram_csb0 (sram_csb0),
        .sram_addr0(sram_addr0),
        .sram_din0 (sram_din0),
        .sram_csb1 (sram_csb1),
        .sram_addr1(sram_addr1),
        .sram_dout1(sram_dout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_csb0) mem[sram_addr0] <= sram_din0;
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sram_csb0 === 1'b0 && sram_csb1 === 1'b0)
            check("sram_same_addr_rw", {63'd0, sram_addr0 == sram_addr1}, 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks n sweep cycles from address 0; optionally pulses flush_req mid-sweep.
    task automatic do_sweep(input int n, input bit expect_done, input int flush_at);
        for (int i = 0; i < n; i++) begin
            if (i == flush_at) flush_req = 1'b1;
            #1;
            check("sweep", {sram_csb0, sram_addr0, sram_din0, sram_csb1, lk_ready, upd_ready, init_done},
                  {1'b0, i[6:0], 17'h0, 1'b1, 1'b0, 1'b0, 1'b0});
            step();
            flush_req = 1'b0;
        end
        if (expect_done) check("init_done_after_sweep", {63'd0, init_done}, 64'd1);
    endtask

    task automatic lookup_set(input logic [6:0] idx, input logic [15:0] tag);
        lk_valid = 1'b1;
        lk_index = idx;
        lk_tag   = tag;
    endtask

    task automatic update_set(input logic [6:0] idx, input logic [16:0] e);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_entry = e;
    endtask

    task automatic check_rsp(input string tag, input logic hit, input logic [16:0] e);
        check(tag, {rsp_valid, rsp_hit, rsp_entry}, {1'b1, hit, e});
    endtask

    initial begin
        logic [15:0] t;
        rst = 1'b1;
        lk_valid = 1'b0; lk_index = '0; lk_tag = '0;
        upd_valid = 1'b0; upd_index = '0; upd_entry = '0;
        flush_req = 1'b0;

        step(); step(); step();
        check("reset_state", {sram_csb0, sram_csb1, rsp_valid, rsp_hit, rsp_entry, init_done, lk_ready},
              {1'b1, 1'b1, 1'b0, 1'b0, 17'h0, 1'b0, 1'b0});
        rst = 1'b0;
        do_sweep(128, 1'b1, -1);
        check("ready_in_run", {lk_ready, upd_ready}, 2'b11);

        // Update then next-cycle lookup reads the new value from the SRAM.
        update_set(7'd5, 17'h1ABCD);
        #1;
        check("upd_strobe", {sram_csb0, sram_addr0, sram_din0}, {1'b0, 7'd5, 17'h1ABCD});
        step();
        upd_valid = 1'b0;
        lookup_set(7'd5, 16'hABCD);
        #1;
        check("lk_strobe", {sram_csb1, sram_addr1}, {1'b0, 7'd5});
        step();
        lk_valid = 1'b0;
        check("rsp_not_yet", {63'd0, rsp_valid}, 64'd0);
        step();
        check_rsp("upd_then_lk", 1'b1, 17'h1ABCD);
        step();
        check("rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);

        // Same-cycle update and lookup to the same set: bypass.
        update_set(7'd9, 17'h10042);
        lookup_set(7'd9, 16'h0042);
        #1;
        check("bypass_strobes", {sram_csb0, sram_csb1}, 2'b01);
        step();
        upd_valid = 1'b0;
        lk_valid = 1'b0;
        step();
        check_rsp("bypass_rsp", 1'b1, 17'h10042);

        // Lookup at E, update at E+1: old value returned.
        lookup_set(7'd5, 16'hABCD);
        step();
        lk_valid = 1'b0;
        update_set(7'd5, 17'h11111);
        step();
        upd_valid = 1'b0;
        check_rsp("lk_then_upd_old", 1'b1, 17'h1ABCD);

        // Back-to-back lookups of sets 0..3, set 2 with a wrong tag.
        for (int i = 0; i < 4; i++) begin
            update_set(i[6:0], {1'b1, 16'h0100 + i[15:0]});
            step();
        end
        upd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t = (i == 2) ? 16'hDEAD : 16'h0100 + i[15:0];
            lookup_set(i[6:0], t);
            step();
            if (i >= 1) check_rsp("b2b_rsp", (i - 1) != 2, {1'b1, 16'h0100 + i[15:0] - 16'd1});
        end
        lk_valid = 1'b0;
        step();
        check_rsp("b2b_rsp_last", 1'b1, 17'h10103);
        step();
        check("b2b_rsp_end", {63'd0, rsp_valid}, 64'd0);

        // Flush: lookup accepted just before it still responds; flush in INIT ignored.
        lookup_set(7'd9, 16'h0042);
        step();
        flush_req = 1'b1;
        #1;
        check("flush_blocks", {lk_ready, upd_ready, sram_csb0, sram_csb1}, 4'b0011);
        step();
        flush_req = 1'b0;
        lk_valid = 1'b0;
        check_rsp("rsp_across_flush", 1'b1, 17'h10042);
        check("flush_init", {63'd0, init_done}, 64'd0);
        do_sweep(128, 1'b1, 10);
        lookup_set(7'd5, 16'hABCD);
        step();
        lk_valid = 1'b0;
        step();
        check_rsp("after_flush", 1'b0, 17'h0);

        // Reset drops a pending response and restarts a partial sweep.
        lookup_set(7'd1, 16'h0101);
        step();
        lk_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("no_read_in_reset", {63'd0, sram_csb1}, 64'd1);
        step();
        check("reset_drops_rsp", {rsp_valid, init_done}, 2'b00);
        rst = 1'b0;
        do_sweep(60, 1'b0, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_sweep(128, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l2_tag_ctrl.md
L2_TAG_CTRL -- requirements
Module: l2_tag_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 7, set index width; TAG_WIDTH, 16, tag width; DATA_WIDTH, 17, entry width (bit 16 = valid, bits 15:0 = tag).
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-003 SHALL have ports: lk_valid  input  1  lookup request; lk_ready  output  1  lookup accept; lk_index  input  7  set; lk_tag  input  16  compare tag.
REQ-004 SHALL have ports: upd_valid  input  1  update request; upd_ready  output  1  update accept; upd_index  input  7  set; upd_entry  input  17  new entry.
REQ-005 SHALL have ports: rsp_valid  output  1  response pulse; rsp_hit  output  1  tag match; rsp_entry  output  17  entry read.
REQ-006 SHALL have ports: flush_req  input  1  invalidate-all pulse; init_done  output  1  high in RUN.
REQ-007 SHALL have SRAM ports: sram_csb0  output  1  write select, active low; sram_addr0  output  7; sram_din0  output  17; sram_csb1  output  1  read select, active low; sram_addr1  output  7; sram_dout1  input  17.

Function
REQ-008 SHALL implement FSM states INIT and RUN; an update is accepted when upd_valid & upd_ready, and a lookup when lk_valid & lk_ready, both at a rising edge.
REQ-009 In INIT, SHALL drive sram_csb0=0, sram_addr0=sweep counter, sram_din0=0, sram_csb1=1, and lk_ready=upd_ready=0.
REQ-010 The sweep counter SHALL start at 0, increment once per cycle, and move the FSM to RUN on the edge that writes index 127, so INIT lasts exactly 128 cycles.
REQ-011 In RUN, SHALL assert upd_ready = !flush_req and lk_ready = !flush_req combinationally.
REQ-012 An accepted update SHALL drive sram_csb0=0, sram_addr0=upd_index and sram_din0=upd_entry combinationally in the accepting cycle; otherwise sram_csb0=1.
REQ-013 An accepted lookup SHALL drive sram_csb1=0 and sram_addr1=lk_index combinationally in the accepting cycle, and SHALL register lk_tag.
REQ-014 Lookup latency SHALL be 1: for a lookup accepted at edge E, the controller SHALL capture sram_dout1 at E+1, and rsp_valid, rsp_entry and rsp_hit SHALL be registered outputs valid for exactly the cycle after E+1.
REQ-015 SHALL compute rsp_hit = rsp_entry[16] & (rsp_entry[15:0] == registered lk_tag).
REQ-016 Throughput SHALL be one lookup per cycle, with no response backpressure.
REQ-017 Same-cycle update and lookup to the same index SHALL force sram_csb1=1 and make rsp_entry equal upd_entry (write-first bypass); the SRAM SHALL never see a same-address read and write in one cycle.
REQ-018 An update at E followed by a lookup of the same index at E+1 SHALL read the new value from the SRAM with no bypass; a lookup at E and an update at E+1 SHALL return the old value.
REQ-019 flush_req high in RUN SHALL block acceptance that cycle, then enter INIT with counter=0 at the next edge; a response owed for a lookup accepted before the flush SHALL still be delivered.
REQ-020 flush_req in INIT SHALL be ignored.
REQ-021 init_done SHALL equal (state == RUN) as a registered output.

Reset
REQ-022 While rst is high at an edge, SHALL set state=INIT, counter=0, rsp_valid=0, rsp_hit=0, rsp_entry=0, init_done=0 and the bypass flag=0; a reset mid-sweep or mid-lookup SHALL restart the sweep at index 0 and drop the pending response.
REQ-023 SRAM strobes SHALL follow REQ-009 from the first cycle after reset, so no SRAM read is issued during reset.

Structure
REQ-024 Package l2_cache_pkg SHALL hold ADDR_WIDTH, TAG_WIDTH, DATA_WIDTH, the VALID_BIT=16 position, the entry typedef and the state enum.
REQ-025 The SRAM macro SHALL be instantiated by the parent, not inside this block, and the block SHALL have no sub-module.

Verification
REQ-026 Reset release -> 128 consecutive writes with sram_din0=0 at addresses 0..127, lk_ready=0 throughout, init_done=1 on cycle 129.
REQ-027 Update idx 5, entry 17'h1ABCD, then next cycle lookup idx 5 tag 16'hABCD -> one cycle later rsp_valid=1, rsp_hit=1, rsp_entry=17'h1ABCD.
REQ-028 Same-cycle update idx 9 with 17'h10042 and lookup idx 9 tag 16'h0042 -> sram_csb1=1 that cycle, then rsp_hit=1 with rsp_entry=17'h10042.
REQ-029 Lookups of idx 0..3 on back-to-back cycles, one of them with a wrong tag -> four consecutive rsp_valid pulses, with rsp_hit=0 only for the mismatch.
REQ-030 flush_req in RUN after idx 5 is valid -> lk_ready=0 that cycle, a 128-cycle sweep, then lookup idx 5 returns rsp_hit=0 and rsp_entry=0.
REQ-031 rst asserted at sweep count 60 -> the sweep restarts at address 0 and init_done stays low until a full 128 writes complete.
